// File: rtl/timer_controller.sv
// Programmable timer channel: prescaled up/down counter with IDLE/RUN/DONE sequencing,
// compare-match pulse and sticky overflow interrupt. Optional PWM output under TIMER_CONTROLLER_PWM_EN.
module timer_controller #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] cfg_rdata,
  output logic [WIDTH-1:0] value,
  output logic             match,
  output logic             irq,
  output logic             running
`ifdef TIMER_CONTROLLER_PWM_EN
  ,
  output logic             pwm
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e                    state_q, state_d;
  logic                      en_q, en_d;
  logic                      oneshot_q, oneshot_d;
  logic                      down_q, down_d;
  logic                      irq_en_q, irq_en_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]          top_q, top_d;
  logic [WIDTH-1:0]          compare_q, compare_d;
  logic [WIDTH-1:0]          value_q, value_d;
  logic                      match_q, match_d;
  logic                      irq_q, irq_d;

  logic ctrl_wr, stop_wr, start_wr, irq_clr, tick, ovf;

`ifdef TIMER_CONTROLLER_PWM_EN
  logic pwm_inv_q, pwm_inv_d;
  logic pwm_q, pwm_d;
`endif

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    down_d     = down_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    psc_d      = psc_q;
    top_d      = top_q;
    compare_d  = compare_q;
    value_d    = value_q;
    match_d    = 1'b0;
    irq_d      = irq_q;
    ovf        = 1'b0;
`ifdef TIMER_CONTROLLER_PWM_EN
    pwm_inv_d  = pwm_inv_q;
`endif

    ctrl_wr  = cfg_we && (cfg_addr == 2'd0);
    stop_wr  = ctrl_wr && !cfg_wdata[0];
    start_wr = ctrl_wr && cfg_wdata[0] && (state_q == ST_IDLE);
    irq_clr  = ctrl_wr && cfg_wdata[4];
    tick     = (state_q == ST_RUN) && (psc_q == prescale_q);

    if (ctrl_wr) begin
      en_d      = cfg_wdata[0];
      oneshot_d = cfg_wdata[1];
      down_d    = cfg_wdata[2];
      irq_en_d  = cfg_wdata[3];
`ifdef TIMER_CONTROLLER_PWM_EN
      pwm_inv_d = cfg_wdata[7];
`endif
    end
    if (cfg_we && (cfg_addr == 2'd1)) prescale_d = cfg_wdata[PRESCALE_WIDTH-1:0];
    if (cfg_we && (cfg_addr == 2'd2)) top_d = cfg_wdata;
    if (cfg_we && (cfg_addr == 2'd3)) compare_d = cfg_wdata;

    // A disabling write wins over any tick in the same cycle; value is frozen.
    if (stop_wr) begin
      state_d = ST_IDLE;
    end else if (start_wr) begin
      state_d = ST_RUN;
      value_d = cfg_wdata[2] ? top_q : '0;
      psc_d   = '0;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        psc_d = '0;
        if (down_q) begin
          ovf = (value_q == '0);
          if (!ovf) value_d = value_q - WIDTH'(1);
        end else begin
          ovf = (value_q >= top_q);
          if (!ovf) value_d = value_q + WIDTH'(1);
        end
        if (ovf) begin
          if (oneshot_q) state_d = ST_DONE;
          else           value_d = down_q ? top_q : '0;
        end
        match_d = (value_d == compare_q);
      end else begin
        psc_d = psc_q + PRESCALE_WIDTH'(1);
      end
    end

    if (ovf && irq_en_q) irq_d = 1'b1;
    else if (irq_clr)    irq_d = 1'b0;

`ifdef TIMER_CONTROLLER_PWM_EN
    pwm_d = (state_d == ST_RUN) && ((value_d < compare_q) ^ pwm_inv_d);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      down_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      psc_q      <= '0;
      top_q      <= '0;
      compare_q  <= '0;
      value_q    <= '0;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      down_q     <= down_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      top_q      <= top_d;
      compare_q  <= compare_d;
      value_q    <= value_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
    end
  end

`ifdef TIMER_CONTROLLER_PWM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_inv_q <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_inv_q <= pwm_inv_d;
      pwm_q     <= pwm_d;
    end
  end
  assign pwm = pwm_q;
`endif

  // CTRL readback exposes the FSM state in [6:5]; irq_clear always reads 0.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: begin
        cfg_rdata[0]   = en_q;
        cfg_rdata[1]   = oneshot_q;
        cfg_rdata[2]   = down_q;
        cfg_rdata[3]   = irq_en_q;
        cfg_rdata[6:5] = state_q;
`ifdef TIMER_CONTROLLER_PWM_EN
        cfg_rdata[7]   = pwm_inv_q;
`endif
      end
      2'd1:    cfg_rdata = WIDTH'(prescale_q);
      2'd2:    cfg_rdata = top_q;
      default: cfg_rdata = compare_q;
    endcase
  end

  assign value   = value_q;
  assign match   = match_q;
  assign irq     = irq_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller: expected values are queued when stimulus is
// applied and popped as outputs are sampled on the falling clock edge.
module tb_timer_controller;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [W-1:0] cfg_wdata;
  logic [W-1:0] cfg_rdata;
  logic [W-1:0] value;
  logic         match;
  logic         irq;
  logic         running;
`ifdef TIMER_CONTROLLER_PWM_EN
  logic         pwm;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  timer_controller #(.WIDTH(W), .PRESCALE_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .value     (value),
    .match     (match),
    .irq       (irq),
    .running   (running)
`ifdef TIMER_CONTROLLER_PWM_EN
    ,
    .pwm       (pwm)
`endif
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge with the write applied.
  task automatic cfg_write(input logic [1:0] a, input logic [W-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = '0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed %0h but scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic expect_chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] e);
    exp_q.push_back(e);
    check(tag, obs);
  endtask

  function automatic logic [W-1:0] b2w(input logic b);
    return {{(W-1){1'b0}}, b};
  endfunction

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    repeat (2) @(negedge clk);
    expect_chk("rst_value",   value,          16'h0);
    expect_chk("rst_irq",     b2w(irq),       16'h0);
    expect_chk("rst_match",   b2w(match),     16'h0);
    expect_chk("rst_running", b2w(running),   16'h0);
    expect_chk("rst_ctrl",    cfg_rdata,      16'h0);
    rst = 1'b1;
    @(negedge clk);

    // Continuous up count, PRESCALE=0, TOP=3, irq_en
    cfg_write(2'd2, 16'd3);
    cfg_write(2'd0, 16'h0009);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(W'(i % 4));
      exp_q.push_back(b2w(i >= 4));
    end
    for (int i = 0; i < 6; i++) begin
      check("up_value", value);
      check("up_irq", b2w(irq));
      @(negedge clk);
    end
    // value is 2 here; clear irq while counting continues
    cfg_write(2'd0, 16'h0019);
    expect_chk("clr_irq",     b2w(irq),     16'h0);
    expect_chk("clr_value",   value,        16'd3);
    expect_chk("clr_running", b2w(running), 16'h1);
    expect_chk("clr_ctrl_rd", cfg_rdata,    16'h0029);
    @(negedge clk);
    expect_chk("reovf_value", value,    16'd0);
    expect_chk("reovf_irq",   b2w(irq), 16'h1);
    repeat (3) @(negedge clk);
    expect_chk("pre_sim_value", value, 16'd3);
    // Overflow and irq_clear land on the same edge
    cfg_write(2'd0, 16'h0019);
    expect_chk("sim_value", value,    16'd0);
    expect_chk("sim_irq",   b2w(irq), 16'h1);

    // Disable with irq clear, then oneshot down, PRESCALE=2, TOP=4
    cfg_write(2'd0, 16'h0010);
    expect_chk("dis_irq",  b2w(irq), 16'h0);
    expect_chk("dis_ctrl", cfg_rdata, 16'h0000);
    cfg_write(2'd1, 16'd2);
    cfg_write(2'd2, 16'd4);
    cfg_write(2'd0, 16'h0007);
    expect_chk("os_ctrl_run", cfg_rdata, 16'h0027);
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back((i < 15) ? W'(4 - i / 3) : 16'd0);
      exp_q.push_back(b2w(i < 15));
      exp_q.push_back(16'h0);
    end
    for (int i = 0; i < 17; i++) begin
      check("os_value", value);
      check("os_running", b2w(running));
      check("os_irq", b2w(irq));
      @(negedge clk);
    end
    expect_chk("os_ctrl_done", cfg_rdata, 16'h0047);
    cfg_write(2'd0, 16'h0007);
    expect_chk("done_norestart_run", b2w(running), 16'h0);
    expect_chk("done_norestart_val", value,        16'd0);

    // Match: TOP=9, COMPARE=6, up continuous
    cfg_write(2'd0, 16'h0000);
    cfg_write(2'd1, 16'd0);
    cfg_write(2'd2, 16'd9);
    cfg_write(2'd3, 16'd6);
    cfg_write(2'd0, 16'h0001);
    for (int j = 0; j < 21; j++) begin
      exp_q.push_back(W'(j % 10));
      exp_q.push_back(b2w((j % 10) == 6));
    end
    for (int j = 0; j < 21; j++) begin
      check("m_value", value);
      check("m_match", b2w(match));
      @(negedge clk);
    end
    cfg_write(2'd3, 16'd10);
    for (int j = 0; j < 25; j++) exp_q.push_back(16'h0);
    for (int j = 0; j < 25; j++) begin
      check("nomatch", b2w(match));
      @(negedge clk);
    end

    // Lower TOP mid-run, PRESCALE=1 so the write lands between ticks
    cfg_write(2'd0, 16'h0000);
    cfg_write(2'd2, 16'd9);
    cfg_write(2'd1, 16'd1);
    cfg_write(2'd0, 16'h0009);
    repeat (14) @(negedge clk);
    expect_chk("lt_pre_value", value,    16'd7);
    expect_chk("lt_pre_irq",   b2w(irq), 16'h0);
    cfg_write(2'd2, 16'd3);
    expect_chk("lt_hold_value", value, 16'd7);
    @(negedge clk);
    expect_chk("lt_ovf_value",   value,        16'd0);
    expect_chk("lt_ovf_irq",     b2w(irq),     16'h1);
    expect_chk("lt_ovf_running", b2w(running), 16'h1);

    // Reset mid-run at value=5
    cfg_write(2'd0, 16'h0000);
    cfg_write(2'd1, 16'd0);
    cfg_write(2'd2, 16'd9);
    cfg_write(2'd0, 16'h0009);
    repeat (5) @(negedge clk);
    expect_chk("mr_pre_value", value,    16'd5);
    expect_chk("mr_pre_irq",   b2w(irq), 16'h1);
    rst = 1'b0;
    #1;
    expect_chk("mr_value",   value,        16'd0);
    expect_chk("mr_irq",     b2w(irq),     16'h0);
    expect_chk("mr_running", b2w(running), 16'h0);
    expect_chk("mr_ctrl",    cfg_rdata,    16'h0);
    repeat (3) @(negedge clk);
    expect_chk("mr_hold_value", value, 16'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    expect_chk("post_rst_value",   value,        16'd0);
    expect_chk("post_rst_running", b2w(running), 16'h0);
    expect_chk("post_rst_match",   b2w(match),   16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
